// File: rtl/line_fetch_pkg.sv
// Shared constants and FSM state type for the line fetch AXI read master.
package line_fetch_pkg;

  localparam int unsigned WORDS_PER_LINE = 640;
  localparam int unsigned BURST_LEN      = 16;
  localparam int unsigned LINE_BYTES     = 2560;
  localparam int unsigned ADDR_W         = 32;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } fetch_state_e;

endpackage

// File: rtl/line_fetch_axi_if.sv
// AXI4 read-channel bundle between the line fetcher and the DDR interconnect.
interface line_fetch_axi_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );

endinterface

// File: rtl/line_fetch_addr_gen.sv
// Line index to frame-buffer start address; constant multiply as shift-add,
// result registered when load is high.
module line_fetch_addr_gen #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LINE_BYTES = 2560,
  parameter int unsigned LINE_W     = 12
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              load,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic [LINE_W-1:0] line_idx,
  output logic [ADDR_W-1:0] line_addr
);

  logic [ADDR_W-1:0] n_ext;
  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] base_aligned;

  // one adder per set bit of LINE_BYTES: 2560 -> (n<<11)+(n<<9)
  always_comb begin
    n_ext  = ADDR_W'(line_idx);
    offset = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (LINE_BYTES[i]) offset = offset + (n_ext << i);
    end
  end

  assign base_aligned = frame_base & ~ADDR_W'(63);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      line_addr <= '0;
    end else if (load) begin
      line_addr <= base_aligned + offset;
    end
  end

endmodule

// File: rtl/line_fetch_axi.sv
// Fetches one video line per request from DDR as BURST_LEN-beat AXI4 INCR
// bursts and streams the words out without backpressure.
module line_fetch_axi #(
  parameter int unsigned WORDS_PER_LINE = line_fetch_pkg::WORDS_PER_LINE,
  parameter int unsigned BURST_LEN      = line_fetch_pkg::BURST_LEN,
  parameter int unsigned LINE_BYTES     = line_fetch_pkg::LINE_BYTES,
  parameter int unsigned ADDR_W         = line_fetch_pkg::ADDR_W
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                enable,
  input  logic [ADDR_W-1:0]   frame_base,
  input  logic                line_req,
  input  logic [11:0]         line_no,
  output logic                line_data_en,
  output logic [31:0]         line_data,
  output logic                busy,
  output logic                overrun,
  output logic                rd_err,
  line_fetch_axi_if.master    m_axi
);

  import line_fetch_pkg::*;

  localparam int unsigned BEAT_W = $clog2(BURST_LEN);
  localparam int unsigned CNT_W  = $clog2(WORDS_PER_LINE + 1);
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * 4);

  fetch_state_e      state_q, state_d;
  logic              line_req_q;
  logic              pend_v_q;
  logic [11:0]       pend_line_q;
  logic              first_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [ADDR_W-1:0] gen_addr;
  logic [BEAT_W-1:0] burst_idx_q;
  logic [CNT_W-1:0]  beat_cnt_q;
  logic              data_en_q;
  logic [31:0]       data_q;
  logic              overrun_q;
  logic              rd_err_q;

  logic        req_edge;
  logic        beat;
  logic        burst_end;
  logic        last_burst;
  logic        line_done;
  logic        accept_new;
  logic        launch_pend;
  logic        launch;
  logic        store_edge;
  logic [11:0] launch_line;

  always_comb begin
    req_edge    = line_req & ~line_req_q;
    beat        = (state_q == DATA) & m_axi.rvalid;
    burst_end   = beat & (burst_idx_q == BEAT_W'(BURST_LEN - 1));
    last_burst  = (beat_cnt_q == CNT_W'(WORDS_PER_LINE - BURST_LEN));
    line_done   = burst_end & last_burst;
    accept_new  = req_edge & (state_q == IDLE) & enable & ~pend_v_q;
    // a held pending line starts as soon as enable allows, from IDLE or at line end
    launch_pend = pend_v_q & enable & ((state_q == IDLE) | line_done);
    launch      = accept_new | launch_pend;
    launch_line = pend_v_q ? pend_line_q : line_no;
    store_edge  = req_edge & ~accept_new & ((state_q != IDLE) | (enable & pend_v_q));
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = ADDR;
      ADDR:    if (!first_q && m_axi.arready) state_d = DATA;
      DATA:    if (burst_end) state_d = (!last_burst || launch_pend) ? ADDR : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  line_fetch_addr_gen #(
    .ADDR_W     (ADDR_W),
    .LINE_BYTES (LINE_BYTES),
    .LINE_W     (12)
  ) u_addr_gen (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .load       (launch),
    .frame_base (frame_base),
    .line_idx   (launch_line),
    .line_addr  (gen_addr)
  );

  // first_q marks the ADDR cycle spent waiting for the address generator
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      line_req_q  <= 1'b0;
      first_q     <= 1'b0;
      araddr_q    <= '0;
      burst_idx_q <= '0;
      beat_cnt_q  <= '0;
      pend_v_q    <= 1'b0;
      pend_line_q <= '0;
      overrun_q   <= 1'b0;
      rd_err_q    <= 1'b0;
      data_en_q   <= 1'b0;
      data_q      <= '0;
    end else begin
      line_req_q <= line_req;
      first_q    <= launch;

      if (first_q) araddr_q <= gen_addr;
      else if (burst_end && !last_burst) araddr_q <= araddr_q + BURST_BYTES;

      if (beat) burst_idx_q <= burst_end ? '0 : burst_idx_q + 1'b1;
      if (burst_end) beat_cnt_q <= last_burst ? '0 : beat_cnt_q + CNT_W'(BURST_LEN);

      if (store_edge) begin
        pend_v_q    <= 1'b1;
        pend_line_q <= line_no;
      end else if (launch_pend) begin
        pend_v_q <= 1'b0;
      end

      if (store_edge && pend_v_q && !launch_pend) overrun_q <= 1'b1;
      // rlast must coincide exactly with the BURST_LEN-th beat
      if (beat && ((m_axi.rresp != AXI_RESP_OKAY) || (m_axi.rlast != burst_end)))
        rd_err_q <= 1'b1;

      data_en_q <= beat;
      if (beat) data_q <= m_axi.rdata;
    end
  end

  assign m_axi.araddr  = araddr_q;
  assign m_axi.arlen   = 8'(BURST_LEN - 1);
  assign m_axi.arsize  = AXI_SIZE_4B;
  assign m_axi.arburst = AXI_BURST_INCR;
  assign m_axi.arvalid = (state_q == ADDR) & ~first_q;
  assign m_axi.rready  = (state_q == DATA);

  assign line_data_en = data_en_q;
  assign line_data    = data_q;
  assign busy         = (state_q != IDLE);
  assign overrun      = overrun_q;
  assign rd_err       = rd_err_q;

endmodule
